// File: rtl/seg_scan.sv
// Time-multiplexed common-anode 7-segment scanner with tear-free word commit.
// A word accepted on the valid/ready port waits in a pending register and only
// becomes visible at the next frame boundary, so a frame never mixes two words.
module seg_scan #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLANK_CYC    = 2,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic [DIGITS-1:0]     in_dp,
    input  logic [DIGITS-1:0]     in_en,
    input  logic [DIGITS-1:0]     in_blink,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_done
);

    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW = $clog2(DIGITS);
    localparam int unsigned FcW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Segment pattern (bits 6:0, active low) for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [FcW-1:0]      fcnt_q, fcnt_d;
    logic                phase_q, phase_d;

    logic                pend_full_q;
    logic [4*DIGITS-1:0] pend_data_q, act_data_q;
    logic [DIGITS-1:0]   pend_dp_q, pend_en_q, pend_blink_q;
    logic [DIGITS-1:0]   act_dp_q, act_en_q, act_blink_q;

    logic [7:0]          seg_d;
    logic [DIGITS-1:0]   an_d;
    logic                last_slot, wrap, accept, commit, lit;
    logic [3:0]          digit;

    assign in_ready = !pend_full_q;

    // Slot/digit/frame counters and handshake decisions.
    always_comb begin
        last_slot = (cnt_q == CntW'(SCAN_DIV - 1));
        wrap      = last_slot && (idx_q == IdxW'(DIGITS - 1));
        cnt_d     = last_slot ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        if (last_slot) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (wrap) begin
            if (fcnt_q == FcW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = !phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        // Pending is never both empty and full, so accept and commit are exclusive;
        // a word captured on a boundary cycle therefore waits for the next boundary.
        accept = in_valid && !pend_full_q;
        commit = wrap && pend_full_q;
    end

    // Output pattern for the current slot, registered below.
    always_comb begin
        digit = act_data_q[{idx_q, 2'b00} +: 4];
        lit   = (cnt_q >= CntW'(BLANK_CYC)) && act_en_q[idx_q]
                && !(act_blink_q[idx_q] && phase_q);
        seg_d = 8'hFF;
        an_d  = '1;
        if (lit) begin
            seg_d = {~act_dp_q[idx_q], hex7(digit)};
            an_d  = ~(DIGITS'(1) << idx_q);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            fcnt_q       <= '0;
            phase_q      <= 1'b0;
            pend_full_q  <= 1'b0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_blink_q <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            act_blink_q  <= '0;
            seg_out      <= 8'hFF;
            an_out       <= '1;
            frame_done   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            fcnt_q     <= fcnt_d;
            phase_q    <= phase_d;
            seg_out    <= seg_d;
            an_out     <= an_d;
            frame_done <= wrap;
            if (accept) begin
                pend_full_q  <= 1'b1;
                pend_data_q  <= in_data;
                pend_dp_q    <= in_dp;
                pend_en_q    <= in_en;
                pend_blink_q <= in_blink;
            end else if (commit) begin
                pend_full_q <= 1'b0;
                act_data_q  <= pend_data_q;
                act_dp_q    <= pend_dp_q;
                act_en_q    <= pend_en_q;
                act_blink_q <= pend_blink_q;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: a cycle-count based display model checked every cycle,
// plus hand-computed expectations at selected frame/slot positions.
module tb_seg_scan;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYC    = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int FL           = DIGITS * SCAN_DIV;

    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_dp = '0;
    logic [3:0]  in_en = '0;
    logic [3:0]  in_blink = '0;
    logic [7:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    seg_scan #(
        .DIGITS      (DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dp     (in_dp),
        .in_en     (in_en),
        .in_blink  (in_blink),
        .seg_out   (seg_out),
        .an_out    (an_out),
        .frame_done(frame_done)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model state: k counts non-reset clock edges since the last reset.
    int          k = 0;
    bit          model_on = 1'b0;
    logic [15:0] m_act_data, m_pend_data;
    logic [3:0]  m_act_dp, m_act_en, m_act_blink;
    logic [3:0]  m_pend_dp, m_pend_en, m_pend_blink;
    bit          m_pend_full;
    logic [7:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_fd, e_rdy;
    int          m_p, m_di, m_ci;
    bit          m_wr, m_ph;

    // Model: position in the frame and blink phase follow from k by division.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            k = 0;
            m_act_data = '0; m_act_dp = '0; m_act_en = '0; m_act_blink = '0;
            m_pend_full = 1'b0;
            e_seg = 8'hFF; e_an = 4'hF; e_fd = 1'b0; e_rdy = 1'b1;
            model_on = 1'b1;
        end else begin
            m_p  = k % FL;
            m_di = m_p / SCAN_DIV;
            m_ci = m_p % SCAN_DIV;
            m_wr = (m_p == FL - 1);
            m_ph = (((k / FL) / BLINK_FRAMES) % 2) == 1;
            e_seg = 8'hFF;
            e_an  = 4'hF;
            if (m_ci >= BLANK_CYC && m_act_en[m_di] && !(m_act_blink[m_di] && m_ph)) begin
                e_an[m_di] = 1'b0;
                e_seg = SEG_TAB[m_act_data[m_di*4 +: 4]];
                if (m_act_dp[m_di]) e_seg[7] = 1'b0;
            end
            e_fd = m_wr;
            if (m_wr && m_pend_full) begin
                m_act_data = m_pend_data; m_act_dp = m_pend_dp;
                m_act_en = m_pend_en; m_act_blink = m_pend_blink;
                m_pend_full = 1'b0;
            end else if (in_valid && !m_pend_full) begin
                m_pend_data = in_data; m_pend_dp = in_dp;
                m_pend_en = in_en; m_pend_blink = in_blink;
                m_pend_full = 1'b1;
            end
            e_rdy = !m_pend_full;
            k++;
        end
    end

    // Compare every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            chk("model_seg", seg_out, e_seg);
            chk("model_an", an_out, e_an);
            chk("model_frame_done", frame_done, e_fd);
            chk("model_in_ready", in_ready, e_rdy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Advance until outputs reflect (frame f, digit i, slot cycle c).
    task automatic at_pos(input int f, input int i, input int c);
        int tgt = f * FL + i * SCAN_DIV + c + 1;
        int g = 0;
        while (k < tgt && g < 4000) begin
            tick();
            g++;
        end
        chk("at_pos_reached", k, tgt);
    endtask

    task automatic lit(input string nm, input logic [7:0] s, input logic [3:0] a);
        chk({nm, "_seg"}, seg_out, s);
        chk({nm, "_an"}, an_out, a);
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                         input logic [3:0] bl);
        in_valid = 1'b1; in_data = d; in_dp = dp; in_en = en; in_blink = bl;
    endtask

    initial begin
        repeat (3) tick();
        lit("reset", 8'hFF, 4'hF);
        chk("reset_rdy", in_ready, 1);
        chk("reset_fd", frame_done, 0);

        // Word 1234 captured on the first edge, shown from frame 1.
        offer(16'h1234, 4'h0, 4'hF, 4'h0);
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t2_rdy_low", in_ready, 0);
        at_pos(0, 2, 3);
        lit("t2_dark_f0", 8'hFF, 4'hF);
        at_pos(0, 3, 7);
        chk("t2_fd_wrap0", frame_done, 1);
        chk("t2_rdy_after_commit", in_ready, 1);
        at_pos(1, 0, 0);
        lit("t2_blank", 8'hFF, 4'hF);
        chk("t2_fd_low", frame_done, 0);
        at_pos(1, 0, 1);
        lit("t2_d0", 8'h99, 4'b1110);
        offer(16'hF000, 4'b1000, 4'hF, 4'h0);
        tick();
        in_valid = 1'b0;
        at_pos(1, 1, 1);
        lit("t2_d1", 8'hB0, 4'b1101);
        at_pos(1, 3, 6);
        chk("t2_fd_pre", frame_done, 0);
        at_pos(1, 3, 7);
        lit("t2_d3", 8'hF9, 4'b0111);
        chk("t2_fd_wrap1", frame_done, 1);

        // F000 with dp on digit 3, then the same word with digit 3 disabled.
        at_pos(2, 0, 1);
        lit("t3_d0", 8'hC0, 4'b1110);
        offer(16'hF000, 4'b1000, 4'b0111, 4'h0);
        tick();
        in_valid = 1'b0;
        at_pos(2, 3, 1);
        lit("t3_f_dp", 8'h0E, 4'b0111);

        // Second word held on the port while the first is pending.
        at_pos(3, 0, 1);
        offer(16'h5678, 4'h0, 4'hF, 4'h0);
        tick();
        in_data = 16'h9ABC;
        at_pos(3, 2, 2);
        lit("t3_d2", 8'hC0, 4'b1011);
        chk("t4_rdy_busy", in_ready, 0);
        at_pos(3, 3, 2);
        lit("t3_d3_off", 8'hFF, 4'hF);
        at_pos(3, 3, 6);
        chk("t4_rdy_still_busy", in_ready, 0);
        at_pos(3, 3, 7);
        chk("t4_rdy_after_wrap", in_ready, 1);
        at_pos(4, 0, 0);
        chk("t4_second_captured", in_ready, 0);
        in_valid = 1'b0;
        at_pos(4, 1, 1);
        lit("t4_first_d1", 8'hF8, 4'b1101);
        at_pos(4, 3, 1);
        lit("t4_first_d3", 8'h92, 4'b0111);
        at_pos(5, 1, 1);
        lit("t4_second_d1", 8'h83, 4'b1101);

        // Offer captured on the wrap edge must wait one more frame.
        at_pos(5, 3, 6);
        offer(16'h8888, 4'h0, 4'hF, 4'b0001);
        tick();
        in_valid = 1'b0;
        chk("t4_wrap_capture", in_ready, 0);
        chk("t4_wrap_fd", frame_done, 1);
        at_pos(6, 0, 1);
        lit("t4_not_yet", 8'hC6, 4'b1110);
        at_pos(6, 3, 7);
        chk("t4_late_commit", in_ready, 1);

        // Blink on digit 0: phase 1 in frames 6,7 and 10,11.
        at_pos(7, 0, 1);
        lit("t5_dark_f7", 8'hFF, 4'hF);
        at_pos(7, 1, 1);
        lit("t5_other_f7", 8'h80, 4'b1101);
        at_pos(8, 0, 1);
        lit("t5_lit_f8", 8'h80, 4'b1110);
        at_pos(9, 0, 3);
        lit("t5_lit_f9", 8'h80, 4'b1110);
        at_pos(10, 0, 1);
        lit("t5_dark_f10", 8'hFF, 4'hF);
        at_pos(10, 2, 5);
        lit("t5_other_f10", 8'h80, 4'b1011);

        // Reset mid-slot 2 with a word pending.
        at_pos(12, 0, 1);
        lit("t6_pre", 8'h80, 4'b1110);
        offer(16'h1111, 4'h0, 4'hF, 4'h0);
        tick();
        in_valid = 1'b0;
        at_pos(12, 2, 3);
        lit("t6_pre_d2", 8'h80, 4'b1011);
        chk("t6_pending_full", in_ready, 0);
        rst_n = 1'b0;
        tick();
        lit("t6_reset", 8'hFF, 4'hF);
        chk("t6_rdy", in_ready, 1);
        chk("t6_fd", frame_done, 0);
        rst_n = 1'b1;
        at_pos(0, 2, 1);
        lit("t6_dark_f0", 8'hFF, 4'hF);
        at_pos(1, 0, 1);
        lit("t6_dark_f1", 8'hFF, 4'hF);
        at_pos(1, 2, 4);
        lit("t6_dark_f1_d2", 8'hFF, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
